// File: rtl/rv_mc_ctrl.sv
`default_nettype none
// ============================================================================
// rv_mc_ctrl : multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for Cilantro.
// Optional sticky illegal-opcode trap enabled by RV_MC_ILLEGAL_TRAP_EN.
// Revision: 1.0
// ============================================================================
module rv_mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [2:0]       imm_type,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic [1:0]       alu_op,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             retire,
  output logic             trap,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    C_NONE    = 4'd0,
    C_LOAD    = 4'd1,
    C_STORE   = 4'd2,
    C_BRANCH  = 4'd3,
    C_OPIMM   = 4'd4,
    C_OP      = 4'd5,
    C_LUI     = 4'd6,
    C_AUIPC   = 4'd7,
    C_JAL     = 4'd8,
    C_JALR    = 4'd9,
    C_ILLEGAL = 4'd10
  } cls_e;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d, opc_cls;
  logic [CNT_W-1:0] instret_q, instret_d;
`ifdef RV_MC_ILLEGAL_TRAP_EN
  logic             trap_q, trap_d;
`endif

  function automatic logic [2:0] imm_of(input cls_e c);
    case (c)
      C_LOAD, C_OPIMM, C_JALR: imm_of = IMM_I;
      C_STORE:                 imm_of = IMM_S;
      C_BRANCH:                imm_of = IMM_B;
      C_LUI, C_AUIPC:          imm_of = IMM_U;
      C_JAL:                   imm_of = IMM_J;
      default:                 imm_of = IMM_NONE;
    endcase
  endfunction

  always_comb begin
    case (opcode)
      7'b0000011: opc_cls = C_LOAD;
      7'b0100011: opc_cls = C_STORE;
      7'b1100011: opc_cls = C_BRANCH;
      7'b0010011: opc_cls = C_OPIMM;
      7'b0110011: opc_cls = C_OP;
      7'b0110111: opc_cls = C_LUI;
      7'b0010111: opc_cls = C_AUIPC;
      7'b1101111: opc_cls = C_JAL;
      7'b1100111: opc_cls = C_JALR;
      default:    opc_cls = C_ILLEGAL;
    endcase
  end

  // Strobes are zero while rst is high so a withdrawn request is visible at once.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'b00;
    imm_type  = IMM_NONE;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    alu_op    = 2'b00;
    reg_we    = 1'b0;
    wb_sel    = 2'b00;
    retire    = 1'b0;
    state_d   = state_q;
    cls_d     = cls_q;
`ifdef RV_MC_ILLEGAL_TRAP_EN
    trap_d    = trap_q;
`endif
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_we   = 1'b1;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          cls_d    = opc_cls;
          imm_type = imm_of(opc_cls);
          if (opc_cls == C_ILLEGAL) begin
`ifdef RV_MC_ILLEGAL_TRAP_EN
            trap_d  = 1'b1;
            state_d = S_TRAP;
`else
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
`endif
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          imm_type = imm_of(cls_q);
          state_d  = S_WB;
          case (cls_q)
            C_LOAD, C_STORE: begin
              alu_b_sel = 1'b1;
              state_d   = S_MEM;
            end
            C_BRANCH: begin
              alu_op  = 2'b10;
              pc_we   = 1'b1;
              pc_sel  = branch_taken ? 2'b01 : 2'b00;
              retire  = 1'b1;
              state_d = S_FETCH;
            end
            C_OPIMM: begin
              alu_b_sel = 1'b1;
              alu_op    = 2'b01;
            end
            C_OP:    alu_op = 2'b01;
            C_LUI: begin
              alu_b_sel = 1'b1;
              alu_op    = 2'b11;
            end
            C_AUIPC, C_JAL: begin
              alu_a_sel = 1'b1;
              alu_b_sel = 1'b1;
            end
            C_JALR:  alu_b_sel = 1'b1;
            default: state_d = S_FETCH;
          endcase
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (cls_q == C_STORE);
          if (dmem_ack) begin
            if (cls_q == C_STORE) begin
              pc_we   = 1'b1;
              retire  = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end
        end
        S_WB: begin
          reg_we  = 1'b1;
          pc_we   = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
          case (cls_q)
            C_LOAD:  wb_sel = 2'b01;
            C_JAL: begin
              wb_sel = 2'b10;
              pc_sel = 2'b01;
            end
            C_JALR: begin
              wb_sel = 2'b10;
              pc_sel = 2'b10;
            end
            default: wb_sel = 2'b00;
          endcase
        end
        default: ;
      endcase
    end
    instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cls_q     <= C_NONE;
      instret_q <= '0;
`ifdef RV_MC_ILLEGAL_TRAP_EN
      trap_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      instret_q <= instret_d;
`ifdef RV_MC_ILLEGAL_TRAP_EN
      trap_q    <= trap_d;
`endif
    end
  end

  assign state   = rst ? 3'd0 : state_q;
  assign instret = rst ? '0 : instret_q;
`ifdef RV_MC_ILLEGAL_TRAP_EN
  assign trap    = rst ? 1'b0 : trap_q;
`else
  assign trap    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv_mc_ctrl.sv
`default_nettype none
// ============================================================================
// tb_rv_mc_ctrl : transaction-level reference bench for rv_mc_ctrl.
// Revision: 1.0
// ============================================================================
module tb_rv_mc_ctrl;

  localparam int CNT_W = 8;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic             clk = 1'b0;
  logic             rst;
  logic [6:0]       opcode;
  logic             branch_taken, imem_ack, dmem_ack;
  logic             imem_req, dmem_req, dmem_we, ir_we, pc_we;
  logic [1:0]       pc_sel;
  logic [2:0]       imm_type;
  logic             alu_a_sel, alu_b_sel;
  logic [1:0]       alu_op;
  logic             reg_we;
  logic [1:0]       wb_sel;
  logic             retire, trap;
  logic [2:0]       state;
  logic [CNT_W-1:0] instret;

  always #5 clk = ~clk;

  rv_mc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .imm_type(imm_type), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .alu_op(alu_op), .reg_we(reg_we), .wb_sel(wb_sel),
    .retire(retire), .trap(trap), .state(state), .instret(instret)
  );

  typedef struct packed {
    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we;
    logic [1:0] pc_sel;
    logic [2:0] imm_type;
    logic       a_sel, b_sel;
    logic [1:0] alu_op;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       retire, trap;
    logic [2:0] state;
  } exp_t;

  int checks   = 0;
  int failures = 0;
  int model_cnt = 0;
  logic [6:0] legal [0:8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] o);
    is_legal = 1'b0;
    for (int i = 0; i < 9; i++) if (legal[i] == o) is_legal = 1'b1;
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      OPC_LOAD, OPC_OPIMM, OPC_JALR: imm_of = 3'd1;
      OPC_STORE:                     imm_of = 3'd2;
      OPC_BRANCH:                    imm_of = 3'd3;
      OPC_LUI, OPC_AUIPC:            imm_of = 3'd4;
      OPC_JAL:                       imm_of = 3'd5;
      default:                       imm_of = 3'd0;
    endcase
  endfunction

  // {alu_a_sel, alu_b_sel, alu_op} in EXEC, from RISC-V operand usage.
  function automatic logic [3:0] alu_of(input logic [6:0] o);
    case (o)
      OPC_LOAD, OPC_STORE, OPC_JALR: alu_of = 4'b0100;
      OPC_BRANCH:                    alu_of = 4'b0010;
      OPC_OPIMM:                     alu_of = 4'b0101;
      OPC_OP:                        alu_of = 4'b0001;
      OPC_LUI:                       alu_of = 4'b0111;
      OPC_AUIPC, OPC_JAL:            alu_of = 4'b1100;
      default:                       alu_of = 4'b0000;
    endcase
  endfunction

  task automatic noise();
    imem_ack     = 1'($urandom_range(0, 1));
    dmem_ack     = 1'($urandom_range(0, 1));
    branch_taken = 1'($urandom_range(0, 1));
  endtask

  // Compare every output against the expected vector for this cycle.
  task automatic step(input exp_t e);
    @(negedge clk);
    chk("imem_req", imem_req, e.imem_req);
    chk("dmem_req", dmem_req, e.dmem_req);
    chk("dmem_we", dmem_we, e.dmem_we);
    chk("ir_we", ir_we, e.ir_we);
    chk("pc_we", pc_we, e.pc_we);
    chk("pc_sel", pc_sel, e.pc_sel);
    chk("imm_type", imm_type, e.imm_type);
    chk("alu_a_sel", alu_a_sel, e.a_sel);
    chk("alu_b_sel", alu_b_sel, e.b_sel);
    chk("alu_op", alu_op, e.alu_op);
    chk("reg_we", reg_we, e.reg_we);
    chk("wb_sel", wb_sel, e.wb_sel);
    chk("retire", retire, e.retire);
    chk("trap", trap, e.trap);
    chk("state", state, e.state);
    chk("instret", instret, rst ? 32'd0 : model_cnt);
    chk("we_overlap", ir_we & (pc_we | reg_we), 1'b0);
    @(posedge clk);
    #1;
    if (e.retire) model_cnt = (model_cnt + 1) & ((1 << CNT_W) - 1);
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      noise();
      e = '0;
      step(e);
    end
    rst = 1'b0;
    model_cnt = 0;
  endtask

  // One instruction: fw/mw wait cycles before imem/dmem ack; abort_mw >= 0
  // stops inside MEM after that many wait cycles (caller then resets).
  task automatic run_instr(input logic [6:0] opc, input int fw, input int mw,
                           input logic bt, input int abort_mw, output int ncyc);
    exp_t e;
    int   n;
    bit   done;
    logic [3:0] al;
    n = 0;
    done = 1'b0;
    for (int i = 0; i <= fw; i++) begin
      noise();
      imem_ack = (i == fw);
      e = '0;
      e.imem_req = 1'b1;
      e.ir_we = (i == fw);
      step(e);
      n++;
    end
    opcode = opc;
    noise();
    e = '0;
    e.state = 3'd1;
    e.imm_type = imm_of(opc);
    if (!is_legal(opc)) begin
`ifndef RV_MC_ILLEGAL_TRAP_EN
      e.pc_we = 1'b1;
      e.retire = 1'b1;
`endif
      done = 1'b1;
    end
    step(e);
    n++;
    if (!done) begin
      noise();
      branch_taken = bt;
      al = alu_of(opc);
      e = '0;
      e.state = 3'd2;
      e.imm_type = imm_of(opc);
      {e.a_sel, e.b_sel, e.alu_op} = al;
      if (opc == OPC_BRANCH) begin
        e.pc_we = 1'b1;
        e.pc_sel = bt ? 2'b01 : 2'b00;
        e.retire = 1'b1;
        done = 1'b1;
      end
      step(e);
      n++;
    end
    if (!done && (opc == OPC_LOAD || opc == OPC_STORE)) begin
      for (int i = 0; i <= mw && !done; i++) begin
        if (abort_mw >= 0 && i == abort_mw) begin
          done = 1'b1;
        end else begin
          noise();
          dmem_ack = (i == mw);
          e = '0;
          e.state = 3'd3;
          e.dmem_req = 1'b1;
          e.dmem_we = (opc == OPC_STORE);
          if (i == mw && opc == OPC_STORE) begin
            e.pc_we = 1'b1;
            e.retire = 1'b1;
            done = 1'b1;
          end
          step(e);
          n++;
        end
      end
    end
    if (!done) begin
      noise();
      e = '0;
      e.state = 3'd4;
      e.reg_we = 1'b1;
      e.pc_we = 1'b1;
      e.retire = 1'b1;
      e.wb_sel = (opc == OPC_LOAD) ? 2'b01 :
                 (opc == OPC_JAL || opc == OPC_JALR) ? 2'b10 : 2'b00;
      e.pc_sel = (opc == OPC_JAL) ? 2'b01 : (opc == OPC_JALR) ? 2'b10 : 2'b00;
      step(e);
      n++;
    end
    ncyc = n;
  endtask

  initial begin
    int nc;
    int sel;
    logic [6:0] opc;
    exp_t e;
    legal[0] = OPC_LOAD;  legal[1] = OPC_STORE; legal[2] = OPC_BRANCH;
    legal[3] = OPC_OPIMM; legal[4] = OPC_OP;    legal[5] = OPC_LUI;
    legal[6] = OPC_AUIPC; legal[7] = OPC_JAL;   legal[8] = OPC_JALR;
    rst = 1'b1;
    opcode = 7'd0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    branch_taken = 1'b0;
    @(posedge clk);
    #1;
    do_reset(3);

    run_instr(OPC_OP, 0, 0, 1'b0, -1, nc);
    chk("op_cycles", nc, 4);
    chk("op_instret", instret, 1);
    run_instr(OPC_LOAD, 0, 3, 1'b0, -1, nc);
    chk("load_wait_cycles", nc, 8);
    run_instr(OPC_BRANCH, 0, 0, 1'b1, -1, nc);
    chk("branch_taken_cycles", nc, 3);
    run_instr(OPC_BRANCH, 0, 0, 1'b0, -1, nc);
    chk("branch_not_taken_cycles", nc, 3);
    run_instr(OPC_JALR, 0, 0, 1'b0, -1, nc);
    chk("jalr_cycles", nc, 4);
    chk("instret_after_directed", instret, 5);

    run_instr(7'b1111111, 0, 0, 1'b0, -1, nc);
    chk("illegal_cycles", nc, 2);
`ifdef RV_MC_ILLEGAL_TRAP_EN
    for (int i = 0; i < 20; i++) begin
      noise();
      e = '0;
      e.state = 3'd5;
      e.trap = 1'b1;
      step(e);
    end
    chk("trap_sticky", trap, 1);
    do_reset(2);
`endif

    for (int k = 0; k < 300; k++) begin
      sel = $urandom_range(0, 9);
      if (sel == 9) opc = 7'($urandom);
      else opc = legal[sel];
`ifdef RV_MC_ILLEGAL_TRAP_EN
      if (!is_legal(opc)) opc = OPC_OP;
`endif
      run_instr(opc, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), -1, nc);
    end

    while (model_cnt != (1 << CNT_W) - 1)
      run_instr(OPC_OPIMM, 0, 0, 1'b0, -1, nc);
    chk("instret_all_ones", instret, 32'hFF);
    run_instr(OPC_OPIMM, 0, 0, 1'b0, -1, nc);
    chk("instret_wrap", instret, 0);

    run_instr(OPC_STORE, 0, 3, 1'b0, 1, nc);
    do_reset(2);
    chk("instret_after_abort", instret, 0);
    run_instr(OPC_STORE, 1, 0, 1'b0, -1, nc);
    chk("store_cycles", nc, 5);
    chk("instret_after_store", instret, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
